// File: rtl/ft_pkg.sv
// Shared definitions for the FT245 host command path (decoder and transmitter).
package ft_pkg;

  localparam logic [3:0] REG_ADDR_TEST    = 4'd0;
  localparam logic [3:0] REG_ADDR_MODE    = 4'd1;
  localparam logic [3:0] REG_ADDR_SCRATCH = 4'd2;
  localparam logic [3:0] REG_ADDR_STATUS  = 4'd3;

  localparam logic REG_READ  = 1'b0;
  localparam logic REG_WRITE = 1'b1;

  localparam logic MODE_STREAM = 1'b1;
  localparam logic MODE_IDLE   = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GET_DATA = 3'd1,
    ST_EXEC     = 3'd2,
    ST_RESP     = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  // Anything above STATUS is unmapped and counts as a bad address.
  function automatic logic is_mapped_addr(input logic [3:0] addr);
    return (addr <= REG_ADDR_STATUS);
  endfunction

endpackage

// File: rtl/ft_reg_file.sv
// Host-visible register file: MODE/SCRATCH storage, write decode, read mux and bad-address flag.
module ft_reg_file
  import ft_pkg::*;
#(
  parameter logic [31:0] TEST_VAL = 32'hDEADBEEF
) (
  input  logic        i_ftdi_clk,
  input  logic        i_reset,
  input  logic        wr_en,
  input  logic [3:0]  addr,
  input  logic [31:0] wr_data,
  input  logic [31:0] status_word,
  output logic [31:0] rd_data,
  output logic        bad_addr,
  output logic [31:0] mode
);

  logic [31:0] scratch;

  // Writes to read-only or unmapped addresses fall through and are dropped.
  always_ff @(posedge i_ftdi_clk or posedge i_reset) begin
    if (i_reset) begin
      mode    <= {MODE_IDLE, 31'd0};
      scratch <= 32'd0;
    end else if (wr_en) begin
      case (addr)
        REG_ADDR_MODE:    mode    <= wr_data;
        REG_ADDR_SCRATCH: scratch <= wr_data;
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_data = 32'd0;
    case (addr)
      REG_ADDR_TEST:    rd_data = TEST_VAL;
      REG_ADDR_MODE:    rd_data = mode;
      REG_ADDR_SCRATCH: rd_data = scratch;
      REG_ADDR_STATUS:  rd_data = status_word;
      default:          rd_data = 32'd0;
    endcase
  end

  assign bad_addr = !is_mapped_addr(addr);

endmodule

// File: rtl/ft_cmd_decoder.sv
// Decodes 2-dword host packets from the FT245 RX FIFO, executes register accesses
// and pushes read responses into the TX FIFO.
module ft_cmd_decoder
  import ft_pkg::*;
#(
  parameter int          TIMEOUT_W = 8,
  parameter logic [31:0] TEST_VAL  = 32'hDEADBEEF
) (
  input  logic        i_ftdi_clk,
  input  logic        i_reset,
  input  logic [31:0] i_rx_data,
  input  logic        i_rx_empty,
  output logic        o_rx_rd,
  output logic [31:0] o_tx_data,
  output logic        o_tx_wr,
  input  logic        i_tx_full,
  output logic [31:0] o_mode,
  output logic        o_stream_stb,
  output logic [15:0] o_cmd_count,
  output logic [7:0]  o_err_count,
  output logic [2:0]  o_fsm
);

  state_t                state;
  logic                  cmd_rw;
  logic [3:0]            cmd_addr;
  logic [31:0]           cmd_data;
  logic [TIMEOUT_W-1:0]  timer;

  logic                  reg_wr_en;
  logic [31:0]           reg_rd_data;
  logic                  reg_bad_addr;
  logic [31:0]           status_word;
  logic [7:0]            err_next;

  assign reg_wr_en   = (state == ST_EXEC) && (cmd_rw == REG_WRITE);
  assign status_word = {o_err_count, o_cmd_count, 8'h00};
  assign err_next    = (o_err_count == 8'hFF) ? o_err_count : o_err_count + 8'd1;
  assign o_fsm       = state;

  ft_reg_file #(
    .TEST_VAL (TEST_VAL)
  ) u_reg_file (
    .i_ftdi_clk  (i_ftdi_clk),
    .i_reset     (i_reset),
    .wr_en       (reg_wr_en),
    .addr        (cmd_addr),
    .wr_data     (cmd_data),
    .status_word (status_word),
    .rd_data     (reg_rd_data),
    .bad_addr    (reg_bad_addr),
    .mode        (o_mode)
  );

  always_ff @(posedge i_ftdi_clk or posedge i_reset) begin
    if (i_reset) begin
      state        <= ST_IDLE;
      cmd_rw       <= REG_READ;
      cmd_addr     <= 4'd0;
      cmd_data     <= 32'd0;
      timer        <= '0;
      o_rx_rd      <= 1'b0;
      o_tx_wr      <= 1'b0;
      o_tx_data    <= 32'd0;
      o_stream_stb <= 1'b0;
      o_cmd_count  <= 16'd0;
      o_err_count  <= 8'd0;
    end else begin
      o_rx_rd      <= 1'b0;
      o_tx_wr      <= 1'b0;
      o_stream_stb <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!i_rx_empty && !o_rx_rd) begin
            cmd_rw   <= i_rx_data[31];
            cmd_addr <= i_rx_data[3:0];
            o_rx_rd  <= 1'b1;
            timer    <= '0;
            state    <= ST_GET_DATA;
          end
        end
        // While o_rx_rd is still high the head is DWORD0, so DWORD1 is only taken after it drops.
        ST_GET_DATA: begin
          if (!o_rx_rd && !i_rx_empty) begin
            cmd_data <= i_rx_data;
            o_rx_rd  <= 1'b1;
            state    <= ST_EXEC;
          end else if (timer == '1) begin
            o_err_count <= err_next;
            state       <= ST_IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_EXEC: begin
          if (reg_bad_addr) begin
            o_err_count <= err_next;
          end
          if (cmd_rw == REG_WRITE) begin
            o_stream_stb <= (cmd_addr == REG_ADDR_MODE) && (cmd_data[31] == MODE_STREAM);
            state        <= ST_DONE;
          end else begin
            o_tx_data <= reg_rd_data;
            state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (!i_tx_full) begin
            o_tx_wr <= 1'b1;
            state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          o_cmd_count <= o_cmd_count + 16'd1;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ft_cmd_decoder.sv
// Scoreboard bench for ft_cmd_decoder: models the RX FIFO and the register map, checks TX pushes.
module tb_ft_cmd_decoder;

  logic        i_ftdi_clk;
  logic        i_reset;
  logic [31:0] i_rx_data;
  logic        i_rx_empty;
  logic        o_rx_rd;
  logic [31:0] o_tx_data;
  logic        o_tx_wr;
  logic        i_tx_full;
  logic [31:0] o_mode;
  logic        o_stream_stb;
  logic [15:0] o_cmd_count;
  logic [7:0]  o_err_count;
  logic [2:0]  o_fsm;

  int checks = 0;
  int failures = 0;

  logic [31:0] rx_q[$];
  logic [31:0] exp_q[$];

  logic [31:0] mdl_mode;
  logic [31:0] mdl_scratch;
  logic [15:0] exp_cmd;
  logic [7:0]  exp_err;
  int          stb_count = 0;
  int          tx_push_count = 0;
  logic        prev_rd = 1'b0;

  ft_cmd_decoder dut (
    .i_ftdi_clk   (i_ftdi_clk),
    .i_reset      (i_reset),
    .i_rx_data    (i_rx_data),
    .i_rx_empty   (i_rx_empty),
    .o_rx_rd      (o_rx_rd),
    .o_tx_data    (o_tx_data),
    .o_tx_wr      (o_tx_wr),
    .i_tx_full    (i_tx_full),
    .o_mode       (o_mode),
    .o_stream_stb (o_stream_stb),
    .o_cmd_count  (o_cmd_count),
    .o_err_count  (o_err_count),
    .o_fsm        (o_fsm)
  );

  initial i_ftdi_clk = 1'b0;
  always #5 i_ftdi_clk = ~i_ftdi_clk;

  task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // First-word fall-through RX FIFO: head and empty flag change only after a clock edge.
  always @(posedge i_ftdi_clk) begin
    if (i_reset) begin
      rx_q.delete();
    end else if (o_rx_rd && rx_q.size() > 0) begin
      void'(rx_q.pop_front());
    end
    i_rx_empty <= (rx_q.size() == 0);
    i_rx_data  <= (rx_q.size() > 0) ? rx_q[0] : 32'd0;
  end

  always @(negedge i_ftdi_clk) begin
    if (!i_reset) begin
      if (o_stream_stb) stb_count++;
      if (o_rx_rd) begin
        check_output("rx_rd_nonempty", {31'd0, i_rx_empty}, 32'd0);
        check_output("rx_rd_gap", {31'd0, prev_rd}, 32'd0);
      end
      if (o_tx_wr) begin
        tx_push_count++;
        check_output("tx_wr_not_full", {31'd0, i_tx_full}, 32'd0);
        if (exp_q.size() == 0) check_output("tx_unexpected_push", exp_q.size(), 32'd1);
        else check_output("tx_data", o_tx_data, exp_q.pop_front());
      end
    end
    prev_rd = o_rx_rd;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge i_ftdi_clk);
  endtask

  // Pushes one packet and updates the register model exactly as the hardware should.
  task automatic apply_stimulus(input logic rw, input logic [3:0] addr, input logic [31:0] data);
    logic [31:0] rd;
    rx_q.push_back({rw, 27'd0, addr});
    rx_q.push_back(data);
    if (rw) begin
      case (addr)
        4'd1: mdl_mode = data;
        4'd2: mdl_scratch = data;
        default: if (addr > 4'd3 && exp_err != 8'hFF) exp_err++;
      endcase
    end else begin
      case (addr)
        4'd0: rd = 32'hDEADBEEF;
        4'd1: rd = mdl_mode;
        4'd2: rd = mdl_scratch;
        4'd3: rd = {exp_err, exp_cmd, 8'h00};
        default: begin
          rd = 32'd0;
          if (exp_err != 8'hFF) exp_err++;
        end
      endcase
      exp_q.push_back(rd);
    end
    exp_cmd++;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!(o_cmd_count == exp_cmd && o_fsm == 3'd0) && n < 100) begin
      tick(1);
      n++;
    end
    check_output({tag, "_cmd"}, {16'd0, o_cmd_count}, {16'd0, exp_cmd});
    check_output({tag, "_err"}, {24'd0, o_err_count}, {24'd0, exp_err});
    check_output({tag, "_mode"}, o_mode, mdl_mode);
    check_output({tag, "_drained"}, exp_q.size(), 32'd0);
  endtask

  task automatic wait_state(input string tag, input logic [2:0] target);
    int n = 0;
    while (o_fsm != target && n < 50) begin
      tick(1);
      n++;
    end
    check_output(tag, {29'd0, o_fsm}, {29'd0, target});
  endtask

  task automatic reset_model();
    mdl_mode    = 32'd0;
    mdl_scratch = 32'd0;
    exp_cmd     = 16'd0;
    exp_err     = 8'd0;
    exp_q.delete();
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_fsm"}, {29'd0, o_fsm}, 32'd0);
    check_output({tag, "_rx_rd"}, {31'd0, o_rx_rd}, 32'd0);
    check_output({tag, "_tx_wr"}, {31'd0, o_tx_wr}, 32'd0);
    check_output({tag, "_tx_data"}, o_tx_data, 32'd0);
    check_output({tag, "_mode"}, o_mode, 32'd0);
    check_output({tag, "_stb"}, {31'd0, o_stream_stb}, 32'd0);
    check_output({tag, "_cmd"}, {16'd0, o_cmd_count}, 32'd0);
    check_output({tag, "_err"}, {24'd0, o_err_count}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int stb_before;
    int push_before;
    i_reset   = 1'b1;
    i_tx_full = 1'b0;
    reset_model();
    tick(3);
    check_reset_values("reset");
    i_reset = 1'b0;
    tick(2);

    $display("[TB] read TEST");
    apply_stimulus(1'b0, 4'd0, $urandom);
    wait_done("read_test");

    $display("[TB] stream MODE write");
    stb_before = stb_count;
    push_before = tx_push_count;
    apply_stimulus(1'b1, 4'd1, 32'h8000_1000);
    wait_done("mode_wr");
    check_output("mode_stb_pulses", stb_count - stb_before, 32'd1);
    check_output("mode_wr_no_push", tx_push_count - push_before, 32'd0);
    apply_stimulus(1'b0, 4'd1, 32'd0);
    wait_done("mode_rd");

    $display("[TB] backpressure");
    apply_stimulus(1'b1, 4'd2, 32'h1234_5678);
    wait_done("scratch_wr");
    i_tx_full = 1'b1;
    push_before = tx_push_count;
    apply_stimulus(1'b0, 4'd2, 32'd0);
    wait_state("reach_resp", 3'd3);
    tick(20);
    check_output("full_hold_state", {29'd0, o_fsm}, 32'd3);
    check_output("full_no_push", tx_push_count - push_before, 32'd0);
    i_tx_full = 1'b0;
    wait_done("scratch_rd");
    check_output("full_one_push", tx_push_count - push_before, 32'd1);

    $display("[TB] inter-dword timeout");
    rx_q.push_back(32'h8000_0002);
    exp_err++;
    tick(300);
    check_output("timeout_idle", {29'd0, o_fsm}, 32'd0);
    check_output("timeout_err", {24'd0, o_err_count}, {24'd0, exp_err});
    check_output("timeout_cmd", {16'd0, o_cmd_count}, {16'd0, exp_cmd});
    apply_stimulus(1'b0, 4'd2, 32'd0);
    wait_done("after_timeout");

    $display("[TB] bad address and read-only writes");
    apply_stimulus(1'b0, 4'd7, 32'd0);
    wait_done("bad_rd");
    apply_stimulus(1'b1, 4'd15, 32'hFFFF_FFFF);
    wait_done("bad_wr");
    apply_stimulus(1'b1, 4'd0, 32'd0);
    wait_done("ro_wr");
    apply_stimulus(1'b0, 4'd0, 32'd0);
    wait_done("ro_rd");
    apply_stimulus(1'b0, 4'd3, 32'd0);
    wait_done("status_rd");
    stb_before = stb_count;
    apply_stimulus(1'b1, 4'd1, 32'h0000_0040);
    wait_done("mode_stop");
    check_output("mode_stop_no_stb", stb_count - stb_before, 32'd0);

    $display("[TB] reset mid-packet");
    rx_q.push_back(32'h8000_0002);
    wait_state("reach_get_data", 3'd1);
    i_reset = 1'b1;
    #1;
    check_reset_values("mid_reset");
    reset_model();
    tick(2);
    i_reset = 1'b0;
    tick(2);
    apply_stimulus(1'b0, 4'd2, 32'd0);
    wait_done("post_reset_rd");
    apply_stimulus(1'b1, 4'd2, 32'hCAFE_0001);
    wait_done("post_reset_wr");
    apply_stimulus(1'b0, 4'd2, 32'd0);
    wait_done("post_reset_rd2");

    tick(5);
    check_output("final_queue", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
